// File: rtl/vpu_sequencer.sv
// VPU pass sequencer: sets the VPU pathway per pass mode, meters two systolic
// lanes into the VPU, counts results per lane and reports completion or a stall.
module vpu_sequencer #(
  parameter int ROWS_W   = 8,
  parameter int WD_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [ROWS_W-1:0] num_rows,
  input  logic              sys_valid_1,
  input  logic              sys_valid_2,
  input  logic              vpu_valid_out_1,
  input  logic              vpu_valid_out_2,
  output logic [3:0]        vpu_data_pathway,
  output logic              in_ready_1,
  output logic              in_ready_2,
  output logic              aux_rd_en_1,
  output logic              aux_rd_en_2,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, CONFIG, RUN, DRAIN, DONE, ERR} state_t;

  localparam logic [8:0] WD_LIM9 = 9'(WD_LIMIT);

  state_t                       state, state_nx;
  logic [1:0]                   mode_q;
  logic [ROWS_W-1:0]            rows_q;
  logic [1:0][ROWS_W-1:0]       in_cnt, out_cnt, out_nx;
  logic [7:0]                   wd;
  logic [1:0]                   sys_v, vout_v, rdy, acc;
  logic                         active, in_full, out_full_nx, wd_hit, aux_mode;

  assign sys_v  = {sys_valid_2, sys_valid_1};
  assign vout_v = {vpu_valid_out_2, vpu_valid_out_1};
  assign active = (state == RUN) || (state == DRAIN);

  // Lane 0 is the "_1" lane, lane 1 the "_2" lane.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rdy[i]    = (state == RUN) && (in_cnt[i] != rows_q);
      acc[i]    = sys_v[i] && rdy[i];
      out_nx[i] = (active && vout_v[i] && (out_cnt[i] != rows_q)) ?
                  out_cnt[i] + 1'b1 : out_cnt[i];
    end
  end

  assign in_full     = (in_cnt[0] == rows_q) && (in_cnt[1] == rows_q);
  assign out_full_nx = (out_nx[0] == rows_q) && (out_nx[1] == rows_q);
  // Fires on the edge where the idle count would reach the limit.
  assign wd_hit      = active && !(|vout_v) && (({1'b0, wd} + 9'd1) == WD_LIM9);
  assign aux_mode    = (mode_q == 2'd1) || (mode_q == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) begin
                 if (mode == 2'd3)            state_nx = ERR;
                 else if (num_rows == '0)     state_nx = DONE;
                 else                         state_nx = CONFIG;
               end
      CONFIG:  state_nx = RUN;
      RUN:     if (wd_hit)                    state_nx = ERR;
               else if (in_full)              state_nx = DRAIN;
      DRAIN:   if (out_full_nx)               state_nx = DONE;
               else if (wd_hit)               state_nx = ERR;
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= '0;
      rows_q <= '0;
    end else if (state == IDLE && start && mode != 2'd3 && num_rows != '0) begin
      mode_q <= mode;
      rows_q <= num_rows;
    end
  end

  // Counters only live in RUN/DRAIN; anything else (incl. abort) returns them to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      wd      <= '0;
    end else if (abort || !active) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      wd      <= '0;
    end else begin
      for (int i = 0; i < 2; i++) in_cnt[i] <= in_cnt[i] + ROWS_W'(acc[i]);
      out_cnt <= out_nx;
      wd      <= (|vout_v) ? 8'd0 : wd + 8'd1;
    end
  end

  always_comb begin
    vpu_data_pathway = 4'b0000;
    if (state == CONFIG || active) begin
      unique case (mode_q)
        2'd0:    vpu_data_pathway = 4'b1100;
        2'd1:    vpu_data_pathway = 4'b1111;
        2'd2:    vpu_data_pathway = 4'b0001;
        default: vpu_data_pathway = 4'b0000;
      endcase
    end
  end

  assign in_ready_1  = rdy[0];
  assign in_ready_2  = rdy[1];
  assign aux_rd_en_1 = acc[0] && aux_mode;
  assign aux_rd_en_2 = acc[1] && aux_mode;
  assign busy        = (state == CONFIG) || active;
  assign done        = (state == DONE);
  assign err         = (state == ERR);

endmodule

// File: tb/tb_vpu_sequencer.sv
// Directed bench for vpu_sequencer; done/err pulses are matched against a
// queue of expected completion events filled when each pass is launched.
module tb_vpu_sequencer;
  localparam int ROWS_W   = 8;
  localparam int WD_LIMIT = 20;
  localparam logic [1:0] EV_DONE = 2'b10;
  localparam logic [1:0] EV_ERR  = 2'b01;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] mode = '0;
  logic [ROWS_W-1:0] num_rows = '0;
  logic sys_valid_1 = 0, sys_valid_2 = 0, vpu_valid_out_1 = 0, vpu_valid_out_2 = 0;
  logic [3:0] vpu_data_pathway;
  logic in_ready_1, in_ready_2, aux_rd_en_1, aux_rd_en_2, busy, done, err;
  logic [10:0] ovec;

  int errors = 0, checks = 0;
  logic [1:0] exp_q[$];

  vpu_sequencer #(.ROWS_W(ROWS_W), .WD_LIMIT(WD_LIMIT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .num_rows(num_rows), .sys_valid_1(sys_valid_1), .sys_valid_2(sys_valid_2),
    .vpu_valid_out_1(vpu_valid_out_1), .vpu_valid_out_2(vpu_valid_out_2),
    .vpu_data_pathway(vpu_data_pathway), .in_ready_1(in_ready_1),
    .in_ready_2(in_ready_2), .aux_rd_en_1(aux_rd_en_1), .aux_rd_en_2(aux_rd_en_2),
    .busy(busy), .done(done), .err(err)
  );

  assign ovec = {vpu_data_pathway, in_ready_1, in_ready_2, aux_rd_en_1, aux_rd_en_2,
                 busy, done, err};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      if (exp_q.size() == 0) chk("unexpected_event", {30'd0, done, err}, 32'd0);
      else                   chk("event", {30'd0, done, err}, {30'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int rdy_n, done_n, done_at, aux1, aux2, err_at;

    // reset holds everything quiet even with active inputs
    start = 1; num_rows = 4; sys_valid_1 = 1; vpu_valid_out_1 = 1; vpu_valid_out_2 = 1;
    repeat (2) tick();
    samp();
    chk("rst_outputs", ovec, 0);
    tick();
    start = 0; num_rows = 0; sys_valid_1 = 0; vpu_valid_out_1 = 0; vpu_valid_out_2 = 0;
    rst = 0;
    samp();
    chk("idle_outputs", ovec, 0);

    // forward pass, lane 1 overruns its outputs
    tick(); start = 1; mode = 0; num_rows = 4; exp_q.push_back(EV_DONE);
    samp(); chk("fwd_idle_busy", busy, 0);
    tick(); start = 0;
    samp(); chk("fwd_cfg", {vpu_data_pathway, in_ready_1, in_ready_2, busy}, {4'b1100, 3'b001});
    rdy_n = 0;
    for (int c = 0; c < 4; c++) begin
      tick(); sys_valid_1 = 1; sys_valid_2 = 1;
      samp(); rdy_n += int'(in_ready_1) + int'(in_ready_2);
    end
    tick(); sys_valid_1 = 0; sys_valid_2 = 0;
    samp();
    chk("fwd_rdy_cnt", rdy_n, 8);
    chk("fwd_rdy_drop", {in_ready_1, in_ready_2, busy}, 3'b001);
    done_n = 0; done_at = -1;
    for (int d = 0; d < 10; d++) begin
      tick(); vpu_valid_out_1 = (d < 6); vpu_valid_out_2 = (d >= 2 && d < 6);
      samp();
      if (done) begin done_n++; done_at = d; end
      if (d == 0) chk("fwd_drain", {busy, vpu_data_pathway, in_ready_1, in_ready_2}, 7'b1110000);
      if (d == 7) chk("fwd_idle_after", {vpu_data_pathway, busy}, 0);
    end
    vpu_valid_out_1 = 0; vpu_valid_out_2 = 0;
    chk("fwd_done_at", done_at, 6);
    chk("fwd_done_n", done_n, 1);

    // transition pass, lane 2 skewed by one cycle
    tick(); start = 1; mode = 1; num_rows = 3; exp_q.push_back(EV_DONE);
    samp();
    tick(); start = 0;
    samp(); chk("tr_cfg_path", vpu_data_pathway, 4'b1111);
    aux1 = 0; aux2 = 0; done_at = -1; done_n = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      sys_valid_1 = (c < 3); sys_valid_2 = (c >= 1 && c < 4);
      vpu_valid_out_1 = (c >= 4 && c < 7); vpu_valid_out_2 = (c >= 5 && c < 8);
      samp();
      aux1 += int'(aux_rd_en_1); aux2 += int'(aux_rd_en_2);
      if (done) begin done_n++; done_at = c; end
      if (c == 3) chk("tr_rdy_c3", {in_ready_1, in_ready_2}, 2'b01);
      if (c == 4) chk("tr_rdy_c4", {in_ready_1, in_ready_2}, 2'b00);
    end
    chk("tr_aux", {aux1[15:0], aux2[15:0]}, {16'd3, 16'd3});
    chk("tr_done_at", done_at, 8);
    chk("tr_done_n", done_n, 1);

    // illegal mode
    tick(); start = 1; mode = 3; num_rows = 5; exp_q.push_back(EV_ERR);
    samp();
    tick(); start = 0; mode = 0;
    samp(); chk("ill_err", {err, busy, vpu_data_pathway}, 6'b100000);
    tick(); samp(); chk("ill_after", ovec, 0);

    // zero-length pass
    tick(); start = 1; mode = 0; num_rows = 0; exp_q.push_back(EV_DONE);
    samp();
    tick(); start = 0;
    samp(); chk("zero_done", {done, busy, vpu_data_pathway}, 6'b100000);
    tick(); samp();

    // watchdog: inputs but no VPU results
    tick(); start = 1; mode = 2; num_rows = 2; exp_q.push_back(EV_ERR);
    samp();
    tick(); start = 0;
    samp(); chk("wd_cfg_path", vpu_data_pathway, 4'b0001);
    aux1 = 0; err_at = -1;
    for (int c = 0; c < 60; c++) begin
      tick(); sys_valid_1 = (c < 2); sys_valid_2 = (c < 2);
      samp();
      aux1 += int'(aux_rd_en_1) + int'(aux_rd_en_2);
      if (err) begin err_at = c; break; end
    end
    chk("wd_err_at", err_at, WD_LIMIT);
    chk("wd_aux", aux1, 4);
    tick(); samp(); chk("wd_idle", {busy, err, vpu_data_pathway}, 0);

    // abort during RUN
    tick(); start = 1; mode = 0; num_rows = 4;
    samp();
    tick(); start = 0;
    samp();
    tick(); sys_valid_1 = 1; sys_valid_2 = 1;
    samp();
    tick(); sys_valid_1 = 0; sys_valid_2 = 0; abort = 1;
    samp(); chk("abort_run_busy", busy, 1);
    tick(); abort = 0;
    samp(); chk("abort_idle", ovec, 0);
    done_n = 0;
    repeat (4) begin tick(); samp(); done_n += int'(done); end
    chk("abort_no_done", done_n, 0);

    // reset pulse during DRAIN
    tick(); start = 1; mode = 0; num_rows = 1;
    samp();
    tick(); start = 0;
    samp();
    tick(); sys_valid_1 = 1; sys_valid_2 = 1;
    samp();
    tick(); sys_valid_1 = 0; sys_valid_2 = 0;
    samp();
    tick();
    samp(); chk("drain_pre", {busy, vpu_data_pathway, in_ready_1, in_ready_2}, 7'b1110000);
    #1 rst = 1;
    #1 chk("rst_drain_outs", ovec, 0);
    tick(); rst = 0;
    samp(); chk("rst_release_idle", ovec, 0);
    repeat (3) begin tick(); samp(); end

    // new pass: ignored start in RUN, simultaneous in/out valids
    tick(); start = 1; mode = 1; num_rows = 2; exp_q.push_back(EV_DONE);
    samp();
    tick(); start = 0;
    samp();
    aux1 = 0; done_n = 0; done_at = -1;
    for (int c = 0; c < 7; c++) begin
      tick();
      sys_valid_1 = (c < 2); sys_valid_2 = (c < 2);
      vpu_valid_out_1 = (c == 1 || c == 2); vpu_valid_out_2 = (c == 1 || c == 2);
      start = (c == 1); mode = (c == 1) ? 2'd3 : 2'd1;
      samp();
      aux1 += int'(aux_rd_en_1) + int'(aux_rd_en_2);
      if (done) begin done_n++; done_at = c; end
      if (c == 1) chk("sim_aux_c1", {aux_rd_en_1, aux_rd_en_2, busy, err}, 4'b1110);
    end
    chk("sim_done_at", done_at, 4);
    chk("sim_done_n", done_n, 1);
    chk("sim_aux", aux1, 4);

    tick(); samp();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vpu_sequencer.md
VPU_SEQUENCER -- requirements
Module: vpu_sequencer

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: clk (rising edge), rst (asynchronous, active-high).
REQ-002 SHALL have parameter ROWS_W, default 8, meaning the row-count width.
REQ-003 SHALL have parameter WD_LIMIT, default 255, meaning the watchdog limit in idle cycles.
REQ-004 Ports, in order (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async reset
- start  in  1  request a VPU pass
- abort  in  1  cancel any pass
- mode  in  2  pass type: 0=forward, 1=transition, 2=backward, 3=illegal
- num_rows  in  ROWS_W  values per lane for the pass
- sys_valid_1 / sys_valid_2  in  1  systolic lane outputs valid
- vpu_valid_out_1 / vpu_valid_out_2  in  1  VPU lane results valid
- vpu_data_pathway  out  4  VPU module enables: bias, lr, loss, lr_d
- in_ready_1 / in_ready_2  out  1  lane may feed the VPU
- aux_rd_en_1 / aux_rd_en_2  out  1  UB read strobe for Y/H operands
- busy  out  1  pass in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse

Function
REQ-005 States SHALL be IDLE, CONFIG, RUN, DRAIN, DONE and ERR; the encoding is free.
REQ-006 Mode to pathway SHALL be 0→1100, 1→1111, 2→0001.
- mode is latched at start acceptance.
- vpu_data_pathway SHALL be 0000 in IDLE, DONE and ERR, and the latched value in CONFIG, RUN and DRAIN.
REQ-007 IDLE with start=1 SHALL act as follows:
- mode 3 → ERR;
- num_rows=0 → DONE;
- otherwise → CONFIG, latching mode and num_rows.
REQ-008 start SHALL be ignored in all states except IDLE.
REQ-009 CONFIG SHALL last exactly one cycle (pathway settle), then → RUN; in_ready_1/2 SHALL be 0 in CONFIG.
REQ-010 In RUN, in_ready_x=1 until the lane's accepted-input count equals the latched num_rows.
- Acceptance is sys_valid_x && in_ready_x.
- Each lane is counted independently.
REQ-011 aux_rd_en_x SHALL equal sys_valid_x && in_ready_x when the latched mode is 1 or 2, and 0 otherwise; it is combinational.
REQ-012 RUN → DRAIN SHALL occur on the cycle after both input counts reach num_rows.
REQ-013 Output counters (one per lane) SHALL increment on vpu_valid_out_x in RUN or DRAIN and saturate at num_rows; extra valids are ignored.
REQ-014 DRAIN → DONE SHALL occur when both output counts equal num_rows, evaluated including the current cycle's valids.
REQ-015 DONE SHALL last one cycle with done=1, then → IDLE; all counters clear on entering IDLE.
REQ-016 Watchdog: an 8-bit counter SHALL run in RUN and DRAIN and clear on any vpu_valid_out_x.
- When it reaches WD_LIMIT → ERR.
- ERR lasts one cycle with err=1, then → IDLE.
REQ-017 abort=1 SHALL force → IDLE on the next edge from any state, with no done or err pulse; abort has priority over all other transitions.
REQ-018 busy SHALL be 1 in CONFIG, RUN and DRAIN, and 0 otherwise.
REQ-019 In a simultaneous input/output valid cycle, both counters SHALL update in that same cycle.

Reset
REQ-020 While rst=1, the block SHALL be in IDLE with all counters 0.
REQ-021 While rst=1, all outputs SHALL be 0 (pathway 0000).
REQ-022 rst asserted mid-pass SHALL abandon the pass without done or err; the first edge after release SHALL see IDLE.

Verification
REQ-023 Forward pass: mode=0, num_rows=4, four valids per lane, four VPU outputs per lane → pathway=1100 from cycle 1; DRAIN reached; done pulses once; pathway returns to 0000.
REQ-024 Transition pass, skewed lanes: mode=1, num_rows=3, lane 2 delayed 1 cycle → aux_rd_en_1/2 each pulse 3 times; in_ready_2 drops one cycle after in_ready_1; done after the last lane-2 output.
REQ-025 Illegal and zero-length starts:
- mode=3 → err pulse, pathway stays 0000.
- num_rows=0 → done pulse next cycle, busy stays 0.
REQ-026 Watchdog: mode=2, num_rows=2, inputs given, no VPU outputs → err exactly WD_LIMIT cycles after the last counter clear; then IDLE.
REQ-027 Abort and reset mid-operation:
- abort during RUN → IDLE next cycle, no done.
- rst pulse during DRAIN → outputs 0 immediately.
- A new start then completes normally.
REQ-028 Ignored start, overrun and simultaneity:
- start pulsed in RUN → ignored.
- Extra vpu_valid_out beyond num_rows → counters saturate, single done.
- Input and output valid in the same cycle → both counters update.
